oldland_dbg_regctl: RTL and testbench
=====================================

Name: oldland_dbg_regctl

Overview:
- Sequences debug-side accesses to the CPU register file.
- Accepts one read/write request at a time from the debug controller and waits for the core to report halted.
- Then drives the regfile debug port (dbg_en / sel / wr_val / wr_en), captures read data after the regfile's 1-cycle registered read latency, and returns a single-cycle response.
- Sits between the debug controller and oldland_regfile; it never touches the CPU-side ports.

Parameters:
- REG_SEL_W, 3, width of register index; regfile holds 2**REG_SEL_W registers.
- HALT_TIMEOUT, 255, max cycles spent in WAIT_HALT before erroring; legal range 1..65535.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
- req_wr  in  1  1=write, 0=read.
- req_sel  in  REG_SEL_W  register index.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_err  out  1  qualifies rsp_valid; 1 = halt timeout, no access performed.
- rsp_rdata  out  32  read data (read), echoed req_wdata (write), 0 on error.
- cpu_halted  in  1  core is halted; regfile ports may be stolen.
- dbg_en  out  1  to regfile; muxes debug port onto read port A and write port.
- dbg_reg_sel  out  REG_SEL_W  to regfile.
- dbg_reg_wr_val  out  32  to regfile.
- dbg_reg_wr_en  out  1  to regfile.
- dbg_reg_val  in  32  from regfile; valid one cycle after dbg_reg_sel is presented with dbg_en high.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered. Reset values: req_ready=1 (IDLE); all other outputs 0.
- Request latch: on acceptance, latch req_wr, req_sel and req_wdata internally. Later changes on req_* are ignored until the next acceptance.
- States: IDLE, WAIT_HALT, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On accept -> WAIT_HALT and clear the timeout counter.
- WAIT_HALT: dbg_en=0.
  - cpu_halted=1 -> ACCESS.
  - Otherwise increment the counter; when it reaches HALT_TIMEOUT -> RESP with err=1, rdata=0.
- ACCESS (exactly 1 cycle): dbg_en=1, dbg_reg_sel=latched sel, dbg_reg_wr_en=latched wr, dbg_reg_wr_val=latched wdata. -> CAPTURE.
- CAPTURE: dbg_en=1, sel held, dbg_reg_wr_en=0. Capture rdata = wr ? wdata : dbg_reg_val. -> RESP.
- RESP: dbg_en=0, rsp_valid=1, rsp_err per path. -> IDLE.
- rsp_rdata/rsp_err hold their values until the next RESP. rsp_valid is high exactly one cycle.
- Latency: if cpu_halted is already high, acceptance occurs in cycle 0 and rsp_valid is high in cycle 4. Each extra WAIT_HALT cycle adds 1.
- cpu_halted dropping during ACCESS/CAPTURE is ignored; the access completes atomically.
- dbg_reg_wr_en is high for exactly one cycle per write and never for reads or errors.
- Reset mid-operation returns to IDLE next edge with dbg_en=0 and dbg_reg_wr_en=0. No response is issued for the aborted request.
- A new request cannot be accepted in the RESP cycle; req_ready rises the cycle after RESP.

Optional Feature:
- Macro: OLDLAND_DBG_REGCTL_AUTOINC_EN.
- Defined: adds input req_inc (1 bit) and an internal REG_SEL_W pointer (reset 0).
  - req_inc=1: the access uses the pointer instead of req_sel.
  - After every non-error access, pointer <= used index + 1, wrapping 2**REG_SEL_W-1 -> 0.
  - Error responses leave the pointer unchanged.
- Not defined: no req_inc port, no pointer; req_sel is always used.

Decomposition:
- Shared package oldland_dbg_pkg holds:
  - state encoding enum (IDLE, WAIT_HALT, ACCESS, CAPTURE, RESP);
  - REG_SEL_W default;
  - DBG_DATA_W=32.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Read, already halted: regfile r3=0xDEADBEEF, cpu_halted=1, read sel=3 -> rsp_valid in cycle 4, rsp_rdata=0xDEADBEEF, rsp_err=0, dbg_reg_wr_en never high.
- Write then read: write sel=5 data=0x12345678 -> single-cycle dbg_reg_wr_en during ACCESS, rsp_rdata=0x12345678; subsequent read sel=5 returns 0x12345678.
- Delayed halt: cpu_halted rises 10 cycles after acceptance -> ACCESS the following cycle, rsp_valid in cycle 14, dbg_en low throughout WAIT_HALT.
- Timeout: HALT_TIMEOUT=8, cpu_halted=0 -> rsp_valid with rsp_err=1, rsp_rdata=0, no regfile write, dbg_en never high.
- Reset mid-ACCESS of a write: rst asserted in the ACCESS cycle -> dbg_en=0, dbg_reg_wr_en=0 next cycle, no rsp_valid, req_ready=1.
- AUTOINC (macro defined): read sel=7 with req_inc=0, then two reads with req_inc=1 -> regs 0 then 1 read (wrap verified).

Source files
------------

// File: rtl/oldland_dbg_regctl_pkg.sv
// Shared definitions for the debug register-file access controller.
package oldland_dbg_pkg;

  localparam int unsigned DEF_REG_SEL_W = 3;
  localparam int unsigned DBG_DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HALT,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } dbg_state_t;

endpackage

// File: rtl/oldland_dbg_regctl_if.sv
// Request/response bus between the debug controller (master) and the
// register access controller (slave). req_inc exists only when
// OLDLAND_DBG_REGCTL_AUTOINC_EN is defined.
interface oldland_dbg_regctl_if
  import oldland_dbg_pkg::*;
#(
  parameter int unsigned REG_SEL_W = DEF_REG_SEL_W
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [REG_SEL_W-1:0]  req_sel;
  logic [DBG_DATA_W-1:0] req_wdata;
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
  logic                  req_inc;
`endif
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DBG_DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_sel, req_wdata,
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    output req_inc,
`endif
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_sel, req_wdata,
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    input  req_inc,
`endif
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/oldland_dbg_regctl.sv
// Sequences debug-side register file accesses: accept one request, wait for
// the core to halt (with timeout), drive the regfile debug port for one
// access cycle, capture read data one cycle later and issue a single-cycle
// response. Optional auto-increment register pointer is enabled by defining
// OLDLAND_DBG_REGCTL_AUTOINC_EN.
module oldland_dbg_regctl
  import oldland_dbg_pkg::*;
#(
  parameter int unsigned REG_SEL_W    = DEF_REG_SEL_W,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  oldland_dbg_regctl_if.slave   bus,
  input  logic                  cpu_halted,
  output logic                  dbg_en,
  output logic [REG_SEL_W-1:0]  dbg_reg_sel,
  output logic [DBG_DATA_W-1:0] dbg_reg_wr_val,
  output logic                  dbg_reg_wr_en,
  input  logic [DBG_DATA_W-1:0] dbg_reg_val
);

  localparam logic [15:0] HALT_LIMIT = 16'(HALT_TIMEOUT);

  dbg_state_t            state;
  logic                  lat_wr;
  logic [REG_SEL_W-1:0]  lat_sel;
  logic [DBG_DATA_W-1:0] lat_wdata;
  logic [15:0]           halt_cnt;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DBG_DATA_W-1:0] rsp_rdata_q;
  logic [REG_SEL_W-1:0]  accept_sel;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
  logic [REG_SEL_W-1:0] sel_ptr;

  // Index used for the access: pointer when auto-increment is requested.
  always_comb begin
    accept_sel = bus.req_inc ? sel_ptr : bus.req_sel;
  end

  // Pointer advances past the used index after every completed access only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ptr <= '0;
    end else if (state == ST_CAPTURE) begin
      sel_ptr <= lat_sel + REG_SEL_W'(1);
    end
  end
`else
  // Without auto-increment the requested index is always used.
  always_comb begin
    accept_sel = bus.req_sel;
  end
`endif

  // Access sequencer; every output is registered and set on the transition
  // into the state in which it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      dbg_en         <= 1'b0;
      dbg_reg_sel    <= '0;
      dbg_reg_wr_val <= '0;
      dbg_reg_wr_en  <= 1'b0;
      lat_wr         <= 1'b0;
      lat_sel        <= '0;
      lat_wdata      <= '0;
      halt_cnt       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_wr      <= bus.req_wr;
            lat_sel     <= accept_sel;
            lat_wdata   <= bus.req_wdata;
            halt_cnt    <= '0;
            req_ready_q <= 1'b0;
            state       <= ST_WAIT_HALT;
          end
        end
        ST_WAIT_HALT: begin
          if (cpu_halted) begin
            dbg_en         <= 1'b1;
            dbg_reg_sel    <= lat_sel;
            dbg_reg_wr_en  <= lat_wr;
            dbg_reg_wr_val <= lat_wdata;
            state          <= ST_ACCESS;
          end else begin
            halt_cnt <= halt_cnt + 16'd1;
            if (halt_cnt + 16'd1 == HALT_LIMIT) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state       <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          dbg_reg_wr_en <= 1'b0;
          state         <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          dbg_en      <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= lat_wr ? lat_wdata : dbg_reg_val;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          req_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          dbg_en        <= 1'b0;
          dbg_reg_wr_en <= 1'b0;
          req_ready_q   <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oldland_dbg_regctl.sv
// Self-checking bench for oldland_dbg_regctl: a directed vector table,
// hand-written reset/auto-increment sequences and randomized transactions
// checked against a transaction-level reference model. Includes a small
// behavioural regfile with 1-cycle registered read.
module tb_oldland_dbg_regctl;
  import oldland_dbg_pkg::*;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned NREG  = 1 << SEL_W;
  localparam int unsigned TO    = 12;
  localparam int          BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             rf_load;
  logic             cpu_halted;
  logic             dbg_en;
  logic [SEL_W-1:0] dbg_reg_sel;
  logic [31:0]      dbg_reg_wr_val;
  logic             dbg_reg_wr_en;
  logic [31:0]      dbg_reg_val;

  always #5 clk = ~clk;

  oldland_dbg_regctl_if #(.REG_SEL_W(SEL_W)) bus ();

  oldland_dbg_regctl #(.REG_SEL_W(SEL_W), .HALT_TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .cpu_halted     (cpu_halted),
    .dbg_en         (dbg_en),
    .dbg_reg_sel    (dbg_reg_sel),
    .dbg_reg_wr_val (dbg_reg_wr_val),
    .dbg_reg_wr_en  (dbg_reg_wr_en),
    .dbg_reg_val    (dbg_reg_val)
  );

  function automatic logic [31:0] init_val(int unsigned i);
    return (i == 3) ? 32'hDEADBEEF : 32'h1000_0000 + i;
  endfunction

  // Behavioural regfile debug port.
  logic [31:0] rf [NREG];
  always @(posedge clk) begin
    if (rf_load) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= init_val(i);
    end else if (dbg_en && dbg_reg_wr_en) begin
      rf[dbg_reg_sel] <= dbg_reg_wr_val;
    end
    dbg_reg_val <= rf[dbg_reg_sel];
  end

  // Transaction-level reference model state.
  logic [31:0] m_mem [NREG];
  int unsigned m_ptr;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_txn(input bit wr, input int unsigned sel, input logic [31:0] wdata,
                           input bit inc, input int unsigned halt_n,
                           output int unsigned e_lat, output logic [31:0] e_rdata, output bit e_err);
    int unsigned used;
    used  = sel;
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    if (inc) used = m_ptr;
`else
    if (inc) used = sel;
`endif
    e_err = (halt_n >= TO);
    e_lat = e_err ? TO + 1 : 4 + halt_n;
    if (e_err) begin
      e_rdata = '0;
    end else begin
      e_rdata = wr ? wdata : m_mem[used];
      if (wr) m_mem[used] = wdata;
      m_ptr = (used + 1) % NREG;
    end
  endtask

  task automatic do_txn(input bit wr, input int unsigned sel, input logic [31:0] wdata,
                        input bit inc, input int unsigned halt_n,
                        output int unsigned lat, output logic [31:0] rdata, output bit err,
                        output int unsigned n_en, output int unsigned n_wr,
                        output int first_en, output bit got);
    got = 0; lat = 0; rdata = '0; err = 0; n_en = 0; n_wr = 0; first_en = -1;
    @(negedge clk);
    check("ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_sel   = SEL_W'(sel);
    bus.req_wdata = wdata;
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    bus.req_inc   = inc;
`endif
    cpu_halted = (halt_n == 0);
    @(negedge clk);
    // Scramble request fields after acceptance; the DUT must ignore them.
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_sel   = SEL_W'($urandom);
    bus.req_wdata = $urandom;
    for (int c = 1; c <= BUDGET; c++) begin
      if (dbg_en) begin
        n_en++;
        if (first_en < 0) first_en = c;
      end
      if (dbg_reg_wr_en) n_wr++;
      if (bus.rsp_valid) begin
        got   = 1;
        lat   = c;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        check("ready_in_resp", 32'(bus.req_ready), 32'd0);
        break;
      end
      cpu_halted = (first_en >= 0) ? 1'($urandom) : (c >= int'(halt_n) + 1);
      @(negedge clk);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL rsp_seen: no rsp_valid within %0d cycles, required one", BUDGET);
    end else begin
      @(negedge clk);
      check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
      check("ready_after", 32'(bus.req_ready), 32'd1);
    end
    cpu_halted = 1'b0;
  endtask

  // use_tab: compare against the hand-written table values instead of the model.
  task automatic run(input string tag, input bit wr, input int unsigned sel, input logic [31:0] wdata,
                     input bit inc, input int unsigned halt_n, input bit use_tab,
                     input int unsigned t_lat, input logic [31:0] t_rdata, input bit t_err);
    int unsigned e_lat, lat, n_en, n_wr;
    logic [31:0] e_rdata, rdata;
    bit e_err, err, got;
    int first_en;
    model_txn(wr, sel, wdata, inc, halt_n, e_lat, e_rdata, e_err);
    if (use_tab) begin
      e_lat = t_lat; e_rdata = t_rdata; e_err = t_err;
    end
    do_txn(wr, sel, wdata, inc, halt_n, lat, rdata, err, n_en, n_wr, first_en, got);
    if (got) begin
      check($sformatf("%s lat", tag), lat, e_lat);
      check($sformatf("%s rdata", tag), rdata, e_rdata);
      check($sformatf("%s err", tag), 32'(err), 32'(e_err));
      check($sformatf("%s wr_en_cnt", tag), n_wr, (wr && !e_err) ? 32'd1 : 32'd0);
      check($sformatf("%s dbg_en_cnt", tag), n_en, e_err ? 32'd0 : 32'd2);
      check($sformatf("%s dbg_en_first", tag), 32'(first_en), e_err ? 32'hFFFF_FFFF : 32'(e_lat - 2));
      check($sformatf("%s rdata_hold", tag), bus.rsp_rdata, e_rdata);
    end
  endtask

  typedef struct {
    bit          wr;
    int unsigned sel;
    logic [31:0] wdata;
    int unsigned halt_n;
    int unsigned lat;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  vec_t tab [8];

  initial begin
    int unsigned e_lat_unused;
    tab[0] = '{0, 3, 32'h0,        0,  4,  32'hDEADBEEF, 0};
    tab[1] = '{1, 5, 32'h12345678, 0,  4,  32'h12345678, 0};
    tab[2] = '{0, 5, 32'h0,        0,  4,  32'h12345678, 0};
    tab[3] = '{0, 3, 32'h0,        10, 14, 32'hDEADBEEF, 0};
    tab[4] = '{1, 2, 32'hCAFEF00D, 12, 13, 32'h0,        1};
    tab[5] = '{0, 2, 32'h0,        0,  4,  32'h10000002, 0};
    tab[6] = '{0, 6, 32'h0,        11, 15, 32'h10000006, 0};
    tab[7] = '{1, 0, 32'hA5A5A5A5, 1,  5,  32'hA5A5A5A5, 0};
    e_lat_unused = 0;

    rst = 1'b1; rf_load = 1'b1; cpu_halted = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_sel = '0; bus.req_wdata = '0;
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    bus.req_inc = 1'b0;
`endif
    for (int unsigned i = 0; i < NREG; i++) m_mem[i] = init_val(i);
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rf_load = 1'b0;

    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst dbg_en", 32'(dbg_en), 32'd0);
    check("rst dbg_reg_wr_en", 32'(dbg_reg_wr_en), 32'd0);
    check("rst dbg_reg_sel", 32'(dbg_reg_sel), 32'd0);
    check("rst dbg_reg_wr_val", dbg_reg_wr_val, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run($sformatf("tab%0d", i), tab[i].wr, tab[i].sel, tab[i].wdata, 1'b0,
          tab[i].halt_n, 1'b1, tab[i].lat, tab[i].rdata, tab[i].err);
    end

    // Reset during the ACCESS cycle of a write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_sel = 3'd4; bus.req_wdata = 32'h0BADF00D;
`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    bus.req_inc = 1'b0;
`endif
    cpu_halted = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid access_wr_en", 32'(dbg_reg_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid dbg_en", 32'(dbg_en), 32'd0);
    check("rstmid wr_en", 32'(dbg_reg_wr_en), 32'd0);
    check("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstmid req_ready", 32'(bus.req_ready), 32'd1);
    begin
      int unsigned stray;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
        if (bus.rsp_valid || dbg_en) stray++;
        @(negedge clk);
      end
      check("rstmid no_activity", stray, 32'd0);
    end
    cpu_halted = 1'b0;
    // The regfile committed the write at the edge that ended ACCESS.
    m_mem[4] = 32'h0BADF00D;
    m_ptr = 0;
    run("after_rst read4", 1'b0, 4, 32'h0, 1'b0, 0, 1'b1, 4, 32'h0BADF00D, 1'b0);

`ifdef OLDLAND_DBG_REGCTL_AUTOINC_EN
    run("ainc sel7", 1'b0, 7, 32'h0, 1'b0, 0, 1'b1, 4, 32'h10000007, 1'b0);
    run("ainc wrap0", 1'b0, 3, 32'h0, 1'b1, 0, 1'b1, 4, 32'hA5A5A5A5, 1'b0);
    run("ainc next1", 1'b0, 6, 32'h0, 1'b1, 0, 1'b1, 4, 32'h10000001, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      bit          r_wr, r_inc;
      int unsigned r_sel, r_halt;
      r_wr   = 1'($urandom);
      r_inc  = 1'($urandom);
      r_sel  = $urandom_range(0, NREG - 1);
      r_halt = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 2);
      run($sformatf("rnd%0d", n), r_wr, r_sel, $urandom, r_inc, r_halt, 1'b0, 0, 32'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
